// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection sequencer and the light-display decoder:
// one-hot colour codes, the phase enumeration and colour lookup helpers.
package traffic_pkg;

  localparam logic [3:0] OFF   = 4'b0000;
  localparam logic [3:0] RED   = 4'b0001;
  localparam logic [3:0] AMBER = 4'b0010;
  localparam logic [3:0] GREEN = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b1000;

  typedef enum logic [2:0] {
    CLR_EW   = 3'd0,
    NS_LEFT  = 3'd1,
    NS_GREEN = 3'd2,
    NS_AMBER = 3'd3,
    CLR_NS   = 3'd4,
    EW_GREEN = 3'd5,
    EW_AMBER = 3'd6
  } state_t;

  // NS light for a given phase; anything unrecognised shows RED.
  function automatic logic [3:0] ns_colour_of(state_t s);
    logic [3:0] c;
    c = OFF;
    case (s)
      NS_LEFT:  c = LEFT;
      NS_GREEN: c = GREEN;
      NS_AMBER: c = AMBER;
      default:  c = RED;
    endcase
    return c;
  endfunction

  // EW light for a given phase; anything unrecognised shows RED.
  function automatic logic [3:0] ew_colour_of(state_t s);
    logic [3:0] c;
    c = OFF;
    case (s)
      EW_GREEN: c = GREEN;
      EW_AMBER: c = AMBER;
      default:  c = RED;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: tick pulses for one clk every TICK_DIV cycles,
// counted from the most recent reset or clr.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  assign tick = (count_q == LAST);

  // Count cycles since the last clear, wrapping to zero on each tick.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset || clr || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Timed two-road intersection sequencer with an on-demand protected NS left turn.
// Outputs are Moore: colours and phase_start are registered alongside the state.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GREEN_SEC = 10,
  parameter int AMBER_SEC = 3,
  parameter int LEFT_SEC  = 5,
  parameter int CLEAR_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_request,
  output logic [3:0] ns_colour,
  output logic [3:0] ew_colour,
  output logic [7:0] sec_remaining,
  output logic       phase_start
);

  state_t     state_q, state_d;
  logic [7:0] elapsed_q;      // whole seconds completed in the current phase
  logic       left_pend_q;
  logic       phase_start_q;
  logic [3:0] ns_colour_q, ew_colour_q;
  logic [7:0] dur;
  logic       phase_done;     // last cycle of the phase (or illegal state): leave on next edge
  logic       tick;

  // Phase length in seconds; illegal encodings fall back to the clearance length.
  function automatic logic [7:0] duration_of(state_t s);
    logic [7:0] d;
    d = 8'(CLEAR_SEC);
    case (s)
      NS_LEFT:            d = 8'(LEFT_SEC);
      NS_GREEN, EW_GREEN: d = 8'(GREEN_SEC);
      NS_AMBER, EW_AMBER: d = 8'(AMBER_SEC);
      default:            d = 8'(CLEAR_SEC);
    endcase
    return d;
  endfunction

  // Prescaler restarts on every phase entry so each phase is exactly D ticks long.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_done),
    .tick  (tick)
  );

  // Next-phase selection: leave when the final second of the phase ticks out.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    dur        = duration_of(state_q);
    phase_done = tick && (elapsed_q == dur - 8'd1);
    state_d    = state_q;
    case (state_q)
      CLR_EW:   if (phase_done) state_d = left_pend_q ? NS_LEFT : NS_GREEN;
      NS_LEFT:  if (phase_done) state_d = NS_GREEN;
      NS_GREEN: if (phase_done) state_d = NS_AMBER;
      NS_AMBER: if (phase_done) state_d = CLR_NS;
      CLR_NS:   if (phase_done) state_d = EW_GREEN;
      EW_GREEN: if (phase_done) state_d = EW_AMBER;
      EW_AMBER: if (phase_done) state_d = CLR_EW;
      default: begin
        state_d    = CLR_EW;
        phase_done = 1'b1;
      end
    endcase
  end

  // State, seconds counter, left-turn latch and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLR_EW;
      elapsed_q     <= 8'd0;
      left_pend_q   <= 1'b0;
      phase_start_q <= 1'b1;
      ns_colour_q   <= RED;
      ew_colour_q   <= RED;
    end else begin
      state_q       <= state_d;
      phase_start_q <= phase_done;
      ns_colour_q   <= ns_colour_of(state_d);
      ew_colour_q   <= ew_colour_of(state_d);
      if (phase_done) begin
        elapsed_q <= 8'd0;
      end else if (tick) begin
        elapsed_q <= elapsed_q + 8'd1;
      end
      // Entering the left phase consumes the request, even one arriving this cycle.
      if (phase_done && state_d == NS_LEFT) begin
        left_pend_q <= 1'b0;
      end else begin
        left_pend_q <= left_pend_q | left_request;
      end
    end
  end

  assign ns_colour     = ns_colour_q;
  assign ew_colour     = ew_colour_q;
  assign phase_start   = phase_start_q;
  assign sec_remaining = dur - elapsed_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: a phase-table reference model pushes the
// expected outputs for each cycle, and a monitor pops and compares them on the falling edge.
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  localparam int TD = 4;
  localparam int GS = 3;
  localparam int AS = 2;
  localparam int LS = 2;
  localparam int CS = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       left_request;
  logic [3:0] ns_colour, ew_colour;
  logic [7:0] sec_remaining;
  logic       phase_start;

  always #5 clk = ~clk;

  traffic_light_fsm #(
    .TICK_DIV  (TD),
    .GREEN_SEC (GS),
    .AMBER_SEC (AS),
    .LEFT_SEC  (LS),
    .CLEAR_SEC (CS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .left_request  (left_request),
    .ns_colour     (ns_colour),
    .ew_colour     (ew_colour),
    .sec_remaining (sec_remaining),
    .phase_start   (phase_start)
  );

  typedef struct packed {
    logic [3:0] ns;
    logic [3:0] ew;
    logic [7:0] sec;
    logic       ps;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Phase schedule in round order: CLR_EW, NS_LEFT, NS_GREEN, NS_AMBER, CLR_NS, EW_GREEN, EW_AMBER.
  logic [3:0] ph_ns  [7] = '{RED, LEFT, GREEN, AMBER, RED, RED, RED};
  logic [3:0] ph_ew  [7] = '{RED, RED, RED, RED, RED, GREEN, AMBER};
  int         ph_sec [7] = '{CS, LS, GS, AS, CS, GS, AS};

  int m_phase = 0;
  int m_cyc   = 0;
  bit m_pend  = 1'b0;
  bit m_start = 1'b0;

  // Reference model: advance one clk, then queue what the lights should show next.
  task automatic model_step();
    exp_t e;
    if (reset) begin
      m_phase = 0;
      m_cyc   = 0;
      m_pend  = 1'b0;
      m_start = 1'b1;
    end else begin
      m_start = 1'b0;
      m_cyc++;
      if (m_cyc == ph_sec[m_phase] * TD) begin
        if (m_phase == 0)      m_phase = m_pend ? 1 : 2;
        else if (m_phase == 6) m_phase = 0;
        else                   m_phase++;
        m_cyc   = 0;
        m_start = 1'b1;
      end
      if (m_start && m_phase == 1) m_pend = 1'b0;
      else                         m_pend = m_pend | left_request;
    end
    e.ns  = ph_ns[m_phase];
    e.ew  = ph_ew[m_phase];
    e.sec = 8'(ph_sec[m_phase] - m_cyc / TD);
    e.ps  = m_start;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare against the scoreboard and check the safety invariants.
  int         left_cycles = 0;
  logic [3:0] prev_ns = RED;
  logic [3:0] prev_ew = RED;
  exp_t       got_e;

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      check("ns_colour",     ns_colour,     got_e.ns);
      check("ew_colour",     ew_colour,     got_e.ew);
      check("sec_remaining", sec_remaining, got_e.sec);
      check("phase_start",   phase_start,   got_e.ps);
      check("ns_onehot", $onehot(ns_colour), 1);
      check("ew_onehot", $onehot(ew_colour), 1);
      check("both_roads_released", (ns_colour != RED) && (ew_colour != RED), 0);
      if (prev_ns == GREEN && ns_colour != GREEN) check("ns_green_then_amber", ns_colour, AMBER);
      if (prev_ns == AMBER && ns_colour != AMBER) check("ns_amber_then_red",   ns_colour, RED);
      if (prev_ew == GREEN && ew_colour != GREEN) check("ew_green_then_amber", ew_colour, AMBER);
      if (prev_ew == AMBER && ew_colour != AMBER) check("ew_amber_then_red",   ew_colour, RED);
      if (ns_colour == LEFT) left_cycles++;
      prev_ns = ns_colour;
      prev_ew = ew_colour;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the model is in phase p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (m_phase != p && n < 200) begin
      step();
      n++;
    end
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase_%0d: timed out after %0d cycles", p, n);
    end
  endtask

  // Stimulus: directed scenarios followed by a long random-request run.
  initial begin
    reset        = 1'b1;
    left_request = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Two full rounds without requests, covering the countdown and phase_start.
    repeat (96) step();

    // Single-cycle request during EW_GREEN: exactly one left phase of 8 clks.
    wait_phase(5);
    left_request = 1'b1;
    step();
    left_request = 1'b0;
    left_cycles  = 0;
    repeat (150) step();
    check("left_cycles_single_pulse", left_cycles, 8);

    // Request held high for three rounds: one 8-clk left phase per round.
    wait_phase(5);
    left_request = 1'b1;
    left_cycles  = 0;
    repeat (168) step();
    check("left_cycles_held", left_cycles, 24);
    left_request = 1'b0;
    repeat (120) step();

    // Reset in the middle of EW_AMBER restarts the sequence from clearance.
    wait_phase(6);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (100) step();

    // Random request traffic with occasional long holds.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 199) == 0) left_request = 1'b1;
      else if (left_request && $urandom_range(0, 7) != 0) left_request = 1'b1;
      else left_request = ($urandom_range(0, 19) == 0);
      step();
    end
    left_request = 1'b0;
    repeat (4) step();
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
